id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the RV32I core. Sits between the decoder/register-file read and the execute-stage arithmetic unit.
- Captures decoded operands and control fields and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Keeps held operands fresh while stalled, and presents registered op1/op2/funct3/funct7/immediate/IMM-type to the arithmetic unit with a valid/ready handshake.

Parameters:
- XLEN, 32, operand/data width
- REG_ADDR_W, 5, register index width
- IMM_W, 12, I-type immediate width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  decode has a valid instruction
- id_ready  out  1  stage can accept this cycle
- id_pc  in  XLEN  instruction PC
- id_rs1_addr, id_rs2_addr  in  REG_ADDR_W  source indices
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_rd_addr  in  REG_ADDR_W  destination index
- id_reg_write  in  1  instruction writes rd
- id_funct3  in  3  funct3 field
- id_funct7  in  7  funct7 field
- id_imm  in  IMM_W  I-type immediate
- id_imm_type  in  1  I-type (immediate) flag
- exm_fwd_valid  in  1  EX/MEM result will write a register
- exm_fwd_rd  in  REG_ADDR_W  EX/MEM destination
- exm_fwd_data  in  XLEN  EX/MEM result
- wb_fwd_valid  in  1  MEM/WB result will write a register
- wb_fwd_rd  in  REG_ADDR_W  MEM/WB destination
- wb_fwd_data  in  XLEN  MEM/WB result
- flush  in  1  kill held and incoming instruction
- ex_ready  in  1  execute consumes this cycle
- ex_valid  out  1  outputs hold a live instruction
- ex_pc  out  XLEN
- ex_op1, ex_op2  out  XLEN  forwarded operands
- ex_rs1_addr, ex_rs2_addr  out  REG_ADDR_W
- ex_rd_addr  out  REG_ADDR_W
- ex_reg_write  out  1
- ex_funct3  out  3
- ex_funct7  out  7
- ex_imm  out  IMM_W
- ex_imm_type  out  1

Behaviour:
- Reset: when rst_n=0 at a clk edge, every registered output is 0.
- id_ready is combinational: id_ready = !ex_valid | ex_ready. It is 0 during reset.
- Transfer occurs when id_valid & id_ready & !flush. All ex_* outputs load at the next edge; latency is 1 cycle.
- Outputs are registered. No combinational path exists from id_* to ex_*.
- Consume without a new transfer (ex_ready=1, no transfer): ex_valid goes to 0. Payload registers hold their values.
- Stall (ex_valid=1, ex_ready=0): payload holds, with one exception. Held ex_op1/ex_op2 re-run forwarding each cycle against the stored ex_rs1_addr/ex_rs2_addr, so producers retiring during a stall are still picked up.
- Forward select for each operand, evaluated at capture and during the stall refresh:
  - exm hit: exm_fwd_valid & exm_fwd_rd==rs & rs!=0 → use exm_fwd_data.
  - else wb hit (same rule with wb_*) → use wb_fwd_data.
  - else use register data at capture, or the held value during a stall.
- EX/MEM has priority over MEM/WB.
- Register index 0 never forwards. An operand whose index is x0 is forced to 0 regardless of the register-file data.
- op2 is forwarded even when id_imm_type=1; the execute unit ignores it.
- flush: ex_valid goes to 0 next edge, and any simultaneous transfer is discarded. Flush dominates ex_ready and id_valid. rst_n dominates flush.
- rst_n=0 in the middle of a stall drops the held instruction. It is not replayed.
- When ex_valid=0, payload values are don't-care, but they must not toggle except on a transfer.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- With the macro defined:
  - Extra outputs stall_cycles (32) and bubble_cycles (32).
  - stall_cycles increments every cycle ex_valid & !ex_ready.
  - bubble_cycles increments every cycle !ex_valid.
  - Both saturate at 0xFFFFFFFF and reset to 0.
  - A new clr_perf input (1 bit, synchronous) zeroes both counters; clr_perf has priority over the increment.
- Without the macro: these ports and their logic do not exist.

Decomposition:
- Package rv_pipe_pkg holds:
  - XLEN/REG_ADDR_W/IMM_W defaults.
  - A packed struct id_ex_t covering pc, rs/rd indices, reg_write, funct3, funct7, imm, imm_type.
  - An enum fwd_sel_e {FWD_NONE, FWD_EXM, FWD_WB}.
- Sub-module fwd_mux: combinational priority select for one operand, taking rs index, base data and both forward buses; it returns data and fwd_sel_e. It is instantiated twice for capture and twice for the stall refresh, or twice with an input mux.

Test Plan:
1. Reset then back-to-back flow: rst_n low 2 cycles → all ex_* = 0. Then id_valid with rs1=3 (data 5), rs2=4 (data 7), ex_ready=1 → next cycle ex_valid=1, ex_op1=5, ex_op2=7, id_ready stays 1.
2. Forward priority: capture rs1=6 with exm_fwd {1,6,0xAAAA0000} and wb_fwd {1,6,0x12345678} → ex_op1=0xAAAA0000. With exm_fwd_valid=0 → ex_op1=0x12345678.
3. x0 guard: rs1=0, id_rs1_data=0xDEADBEEF, exm_fwd {1,0,0xFFFFFFFF} → ex_op1=0.
4. Stall refresh: hold ex_ready=0 with ex_rs2_addr=9 and ex_op2=1. Two cycles later pulse wb_fwd {1,9,0x55} → ex_op2=0x55 next cycle. id_ready=0 throughout the stall; no new capture.
5. Flush precedence: ex_valid=1, ex_ready=0, id_valid=1, flush=1 → next cycle ex_valid=0 and the incoming instruction does not appear. Then flush=0 → the next instruction is accepted normally.
6. (ID_EX_PERF_EN) 3 stall cycles then 2 idle cycles → stall_cycles=3, bubble_cycles=2. clr_perf pulse → both read 0 next cycle.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared types for the RV32I pipeline: width defaults, ID/EX payload and forward-select encoding.
package rv_pipe_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned IMM_W      = 12;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [IMM_W-1:0]      imm;
    logic                  imm_type;
  } id_ex_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EXM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Priority operand forwarding for one source: EX/MEM beats MEM/WB, x0 always reads zero.
import rv_pipe_pkg::*;

module fwd_mux #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [XLEN-1:0]       base_i,
  input  logic                  exm_valid_i,
  input  logic [REG_ADDR_W-1:0] exm_rd_i,
  input  logic [XLEN-1:0]       exm_data_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]       wb_data_i,
  output logic [XLEN-1:0]       data_o,
  output fwd_sel_e              sel_o
);

  always_comb begin
    sel_o  = FWD_NONE;
    data_o = base_i;
    if (rs_i == '0) begin
      data_o = '0;
    end else if (exm_valid_i && (exm_rd_i == rs_i)) begin
      sel_o  = FWD_EXM;
      data_o = exm_data_i;
    end else if (wb_valid_i && (wb_rd_i == rs_i)) begin
      sel_o  = FWD_WB;
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and stall-time operand refresh.
// Optional performance counters are built when ID_EX_PERF_EN is defined.
import rv_pipe_pkg::*;

module id_ex_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned IMM_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_reg_write,
  input  logic [2:0]            id_funct3,
  input  logic [6:0]            id_funct7,
  input  logic [IMM_W-1:0]      id_imm,
  input  logic                  id_imm_type,
  input  logic                  exm_fwd_valid,
  input  logic [REG_ADDR_W-1:0] exm_fwd_rd,
  input  logic [XLEN-1:0]       exm_fwd_data,
  input  logic                  wb_fwd_valid,
  input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]       wb_fwd_data,
  input  logic                  flush,
  input  logic                  ex_ready,
`ifdef ID_EX_PERF_EN
  input  logic                  clr_perf,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           bubble_cycles,
`endif
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_op1,
  output logic [XLEN-1:0]       ex_op2,
  output logic [REG_ADDR_W-1:0] ex_rs1_addr,
  output logic [REG_ADDR_W-1:0] ex_rs2_addr,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic [2:0]            ex_funct3,
  output logic [6:0]            ex_funct7,
  output logic [IMM_W-1:0]      ex_imm,
  output logic                  ex_imm_type
);

  logic                  valid_q;
  id_ex_t                pay_q, pay_d;
  logic [XLEN-1:0]       op1_q, op2_q;
  logic                  transfer;
  logic [REG_ADDR_W-1:0] rs1_sel, rs2_sel;
  logic [XLEN-1:0]       base1, base2, fwd1, fwd2;
  fwd_sel_e              sel1, sel2;

  assign id_ready = rst_n & (~valid_q | ex_ready);
  assign transfer = id_valid & id_ready & ~flush;

  always_comb begin
    pay_d           = '0;
    pay_d.pc        = id_pc;
    pay_d.rs1       = id_rs1_addr;
    pay_d.rs2       = id_rs2_addr;
    pay_d.rd        = id_rd_addr;
    pay_d.reg_write = id_reg_write;
    pay_d.funct3    = id_funct3;
    pay_d.funct7    = id_funct7;
    pay_d.imm       = id_imm;
    pay_d.imm_type  = id_imm_type;
  end

  // One mux pair serves both capture and stall refresh: when the stage cannot
  // accept, the forwarders look at the held indices and held operand values.
  assign rs1_sel = id_ready ? id_rs1_addr : pay_q.rs1;
  assign rs2_sel = id_ready ? id_rs2_addr : pay_q.rs2;
  assign base1   = id_ready ? id_rs1_data : op1_q;
  assign base2   = id_ready ? id_rs2_data : op2_q;

  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd1 (
    .rs_i(rs1_sel), .base_i(base1),
    .exm_valid_i(exm_fwd_valid), .exm_rd_i(exm_fwd_rd), .exm_data_i(exm_fwd_data),
    .wb_valid_i(wb_fwd_valid), .wb_rd_i(wb_fwd_rd), .wb_data_i(wb_fwd_data),
    .data_o(fwd1), .sel_o(sel1)
  );

  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd2 (
    .rs_i(rs2_sel), .base_i(base2),
    .exm_valid_i(exm_fwd_valid), .exm_rd_i(exm_fwd_rd), .exm_data_i(exm_fwd_data),
    .wb_valid_i(wb_fwd_valid), .wb_rd_i(wb_fwd_rd), .wb_data_i(wb_fwd_data),
    .data_o(fwd2), .sel_o(sel2)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (transfer) begin
      valid_q <= 1'b1;
      pay_q   <= pay_d;
      op1_q   <= fwd1;
      op2_q   <= fwd2;
    end else if (valid_q && !ex_ready) begin
      if (sel1 != FWD_NONE) op1_q <= fwd1;
      if (sel2 != FWD_NONE) op2_q <= fwd2;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pay_q.pc;
  assign ex_op1       = op1_q;
  assign ex_op2       = op2_q;
  assign ex_rs1_addr  = pay_q.rs1;
  assign ex_rs2_addr  = pay_q.rs2;
  assign ex_rd_addr   = pay_q.rd;
  assign ex_reg_write = pay_q.reg_write;
  assign ex_funct3    = pay_q.funct3;
  assign ex_funct7    = pay_q.funct7;
  assign ex_imm       = pay_q.imm;
  assign ex_imm_type  = pay_q.imm_type;

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_q, bubble_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr_perf) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (valid_q && !ex_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (!valid_q && (bubble_q != '1))            bubble_q <= bubble_q + 32'd1;
    end
  end

  assign stall_cycles  = stall_q;
  assign bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (perf counters checked when ID_EX_PERF_EN is defined).
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_reg_write, id_imm_type;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [11:0] id_imm;
  logic        exm_fwd_valid, wb_fwd_valid;
  logic [4:0]  exm_fwd_rd, wb_fwd_rd;
  logic [31:0] exm_fwd_data, wb_fwd_data;
  logic        flush, ex_ready, ex_valid;
  logic [31:0] ex_pc, ex_op1, ex_op2;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic        ex_reg_write, ex_imm_type;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [11:0] ex_imm;
`ifdef ID_EX_PERF_EN
  logic        clr_perf;
  logic [31:0] stall_cycles, bubble_cycles;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .REG_ADDR_W(5), .IMM_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rd_addr(id_rd_addr),
    .id_reg_write(id_reg_write), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_imm(id_imm), .id_imm_type(id_imm_type),
    .exm_fwd_valid(exm_fwd_valid), .exm_fwd_rd(exm_fwd_rd), .exm_fwd_data(exm_fwd_data),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .flush(flush), .ex_ready(ex_ready),
`ifdef ID_EX_PERF_EN
    .clr_perf(clr_perf), .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles),
`endif
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_imm(ex_imm), .ex_imm_type(ex_imm_type)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_pc = '0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_data = '0; id_rs2_data = '0;
    id_rd_addr = '0; id_reg_write = 1'b0; id_funct3 = '0; id_funct7 = '0;
    id_imm = '0; id_imm_type = 1'b0;
    exm_fwd_valid = 1'b0; exm_fwd_rd = '0; exm_fwd_data = '0;
    wb_fwd_valid = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
    flush = 1'b0; ex_ready = 1'b1;
`ifdef ID_EX_PERF_EN
    clr_perf = 1'b0;
`endif

    // Reset
    step(); step();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_op1", ex_op1, 32'd0);
    chk("rst_op2", ex_op2, 32'd0);
    chk("rst_ready", {31'd0, id_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {31'd0, id_ready}, 32'd1);

    // Basic capture
    id_valid = 1'b1; id_pc = 32'h100;
    id_rs1_addr = 5'd3; id_rs1_data = 32'd5; id_rs2_addr = 5'd4; id_rs2_data = 32'd7;
    id_rd_addr = 5'd2; id_reg_write = 1'b1; id_funct3 = 3'b101; id_funct7 = 7'h20;
    id_imm = 12'h123; id_imm_type = 1'b1;
    step();
    chk("t1_valid", {31'd0, ex_valid}, 32'd1);
    chk("t1_op1", ex_op1, 32'd5);
    chk("t1_op2", ex_op2, 32'd7);
    chk("t1_pc", ex_pc, 32'h100);
    chk("t1_rd", {27'd0, ex_rd_addr}, 32'd2);
    chk("t1_f3", {29'd0, ex_funct3}, 32'd5);
    chk("t1_f7", {25'd0, ex_funct7}, 32'h20);
    chk("t1_imm", {20'd0, ex_imm}, 32'h123);
    chk("t1_immtype", {31'd0, ex_imm_type}, 32'd1);
    chk("t1_regwr", {31'd0, ex_reg_write}, 32'd1);
    chk("t1_ready", {31'd0, id_ready}, 32'd1);

    // Forward priority
    id_pc = 32'h104; id_rs1_addr = 5'd6; id_rs1_data = 32'h1111;
    exm_fwd_valid = 1'b1; exm_fwd_rd = 5'd6; exm_fwd_data = 32'hAAAA0000;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd6; wb_fwd_data = 32'h12345678;
    step();
    chk("t2_exm_prio", ex_op1, 32'hAAAA0000);
    chk("t2_op2_nofwd", ex_op2, 32'd7);
    chk("t2_rs1", {27'd0, ex_rs1_addr}, 32'd6);
    exm_fwd_valid = 1'b0;
    step();
    chk("t2_wb_fwd", ex_op1, 32'h12345678);
    wb_fwd_valid = 1'b0;

    // x0 guard
    id_rs1_addr = 5'd0; id_rs1_data = 32'hDEADBEEF;
    id_rs2_addr = 5'd0; id_rs2_data = 32'h77;
    exm_fwd_valid = 1'b1; exm_fwd_rd = 5'd0; exm_fwd_data = 32'hFFFFFFFF;
    step();
    chk("t3_x0_op1", ex_op1, 32'd0);
    chk("t3_x0_op2", ex_op2, 32'd0);
    exm_fwd_valid = 1'b0;

    // Stall refresh
    id_pc = 32'h108; id_rs1_addr = 5'd3; id_rs1_data = 32'd5;
    id_rs2_addr = 5'd9; id_rs2_data = 32'd1;
    step();
    chk("t4_cap_op2", ex_op2, 32'd1);
    ex_ready = 1'b0; id_pc = 32'h200; id_rs2_data = 32'd2;
    #1;
    chk("t4_ready_low", {31'd0, id_ready}, 32'd0);
    step();
    chk("t4_hold_op2", ex_op2, 32'd1);
    chk("t4_hold_pc", ex_pc, 32'h108);
    step();
    chk("t4_ready_low2", {31'd0, id_ready}, 32'd0);
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd9; wb_fwd_data = 32'h55;
    step();
    wb_fwd_valid = 1'b0;
    chk("t4_refresh_op2", ex_op2, 32'h55);
    chk("t4_refresh_op1", ex_op1, 32'd5);
    chk("t4_pc_still", ex_pc, 32'h108);
    chk("t4_valid", {31'd0, ex_valid}, 32'd1);
    step();
    chk("t4_op2_kept", ex_op2, 32'h55);

    // Flush precedence while stalled with an incoming instruction
    id_valid = 1'b1; id_pc = 32'h300; flush = 1'b1;
    step();
    chk("t5_flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("t5_flush_pc", ex_pc, 32'h108);
    flush = 1'b0; ex_ready = 1'b1; id_rs1_addr = 5'd5; id_rs1_data = 32'h99;
    step();
    chk("t5_next_valid", {31'd0, ex_valid}, 32'd1);
    chk("t5_next_pc", ex_pc, 32'h300);
    chk("t5_next_op1", ex_op1, 32'h99);

    // Consume without transfer
    id_valid = 1'b0;
    step();
    chk("cons_valid", {31'd0, ex_valid}, 32'd0);
    chk("cons_pc_hold", ex_pc, 32'h300);

    // Reset in the middle of a stall
    id_valid = 1'b1; id_pc = 32'h400;
    step();
    id_valid = 1'b0; ex_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("rst_stall_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_stall_pc", ex_pc, 32'd0);
    rst_n = 1'b1; ex_ready = 1'b1;
    step();
    chk("rst_no_replay", {31'd0, ex_valid}, 32'd0);

`ifdef ID_EX_PERF_EN
    // 3 stall cycles, then 2 idle cycles
    clr_perf = 1'b1; id_valid = 1'b1; ex_ready = 1'b0;
    step();
    clr_perf = 1'b0; id_valid = 1'b0;
    chk("perf_clr_stall", stall_cycles, 32'd0);
    chk("perf_clr_bubble", bubble_cycles, 32'd0);
    step(); step(); step();
    chk("perf_stall3", stall_cycles, 32'd3);
    ex_ready = 1'b1;
    step();
    step(); step();
    chk("perf_stall_final", stall_cycles, 32'd3);
    chk("perf_bubble2", bubble_cycles, 32'd2);
    clr_perf = 1'b1;
    step();
    clr_perf = 1'b0;
    chk("perf_zero_stall", stall_cycles, 32'd0);
    chk("perf_zero_bubble", bubble_cycles, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
